// File: rtl/idli_pcu_m.sv
// idli bit-serial program counter unit.
// Streams the PC and link value LSB slice first and writes back the next PC.
module idli_pcu_m #(
  parameter int PC_W = 16,
  parameter int SLICE_W = 4,
  parameter logic [PC_W-1:0] INC = PC_W'(2),
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               i_pcu_gck,
  input  logic               i_pcu_rst,
  input  logic               i_pcu_stall,
  input  logic               i_pcu_redir_vld,
  input  logic               i_pcu_redir_rel,
  input  logic [SLICE_W-1:0] i_pcu_redir_slice,
  output logic [SLICE_W-1:0] o_pcu_pc_slice,
  output logic [SLICE_W-1:0] o_pcu_link_slice,
  output logic               o_pcu_first,
  output logic               o_pcu_last,
  output logic [PC_W-1:0]    o_pcu_pc_q
);

  localparam int NSLICE = PC_W / SLICE_W;
  localparam int CTR_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NSLICE - 1);

  if ((PC_W % SLICE_W) != 0) begin : g_bad_width
    $fatal(1, "idli_pcu_m: PC_W must be a multiple of SLICE_W");
  end

  logic [PC_W-1:0]    pc_q;
  logic [CTR_W-1:0]   ctr;
  logic               carry_q;
  logic               lcarry_q;
  logic               redir_q;
  logic               rel_q;

  logic               first;
  logic               last;
  logic [SLICE_W-1:0] pc_slice;
  logic [PC_W-1:0]    inc_sh;
  logic [SLICE_W-1:0] inc_s;
  logic               cin;
  logic               lcin;
  logic               eff_redir;
  logic               eff_rel;
  logic [SLICE_W:0]   lsum;
  logic [SLICE_W:0]   wsum;
  logic [PC_W-1:0]    pc_nxt;
  logic               c_nxt;
  logic               lc_nxt;

  assign first    = (ctr == '0);
  assign last     = (ctr == CTR_LAST);
  assign pc_slice = pc_q[SLICE_W-1:0];
  assign inc_sh   = INC >> (SLICE_W * int'(ctr));
  assign inc_s    = inc_sh[SLICE_W-1:0];

  // Carries only chain within a period; slice 0 always starts clean.
  assign cin  = first ? 1'b0 : carry_q;
  assign lcin = first ? 1'b0 : lcarry_q;

  assign eff_redir = first ? i_pcu_redir_vld : redir_q;
  assign eff_rel   = first ? i_pcu_redir_rel : rel_q;

  assign lsum = {1'b0, pc_slice} + {1'b0, inc_s}
              + {{SLICE_W{1'b0}}, lcin};

  always_comb begin
    wsum = '0;
    if (!eff_redir) begin
      wsum = {1'b0, pc_slice} + {1'b0, inc_s}
           + {{SLICE_W{1'b0}}, cin};
    end else if (!eff_rel) begin
      wsum = {1'b0, i_pcu_redir_slice};
    end else begin
      wsum = {1'b0, pc_slice} + {1'b0, i_pcu_redir_slice}
           + {{SLICE_W{1'b0}}, cin};
    end
  end

  if (NSLICE > 1) begin : g_multi
    assign pc_nxt = {wsum[SLICE_W-1:0], pc_q[PC_W-1:SLICE_W]};
    assign c_nxt  = wsum[SLICE_W];
    assign lc_nxt = lsum[SLICE_W];
  end else begin : g_single
    assign pc_nxt = wsum[SLICE_W-1:0];
    assign c_nxt  = 1'b0;
    assign lc_nxt = 1'b0;
  end

  always_ff @(posedge i_pcu_gck or posedge i_pcu_rst) begin
    if (i_pcu_rst) begin
      pc_q     <= RESET_PC;
      ctr      <= '0;
      carry_q  <= 1'b0;
      lcarry_q <= 1'b0;
      redir_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else if (!i_pcu_stall) begin
      pc_q     <= pc_nxt;
      carry_q  <= c_nxt;
      lcarry_q <= lc_nxt;
      ctr      <= last ? '0 : ctr + CTR_W'(1);
      if (first) begin
        redir_q <= i_pcu_redir_vld;
        rel_q   <= i_pcu_redir_rel;
      end
    end
  end

  assign o_pcu_pc_slice   = pc_slice;
  assign o_pcu_link_slice = lsum[SLICE_W-1:0];
  assign o_pcu_first      = first;
  assign o_pcu_last       = last;
  assign o_pcu_pc_q       = pc_q;

endmodule

// File: doc/idli_pcu_m.md
Name: idli_pcu_m

Overview:
- Parametrised bit-serial program counter unit; successor to the fixed 16-bit/4-bit nibble PC.
- Streams the current PC one slice per cycle, LSB slice first, over an instruction period of NSLICE = PC_W/SLICE_W cycles.
- Sequences its own slice counter and writes back PC+INC, an absolute branch target, or PC+offset (relative branch).
- Also streams the link value (PC+INC) for call instructions.

Parameters:
- PC_W, 16: PC width in bits. Must be a multiple of SLICE_W.
- SLICE_W, 4: bits transferred per cycle.
- INC, 2: sequential increment per instruction, range 0..2^PC_W-1.
- RESET_PC, 0: PC value after reset.

Ports:
- i_pcu_gck  in  1  clock; all state is on the rising edge.
- i_pcu_rst  in  1  reset; asynchronous, active-high.
- i_pcu_stall  in  1  freeze all state this cycle.
- i_pcu_redir_vld  in  1  redirect request; sampled only when o_pcu_first=1.
- i_pcu_redir_rel  in  1  redirect mode: 0 = absolute target, 1 = PC-relative offset. Sampled with vld.
- i_pcu_redir_slice  in  SLICE_W  target/offset slice, LSB first. Aligned to o_pcu_pc_slice.
- o_pcu_pc_slice  out  SLICE_W  current PC slice.
- o_pcu_link_slice  out  SLICE_W  slice of PC+INC.
- o_pcu_first  out  1  slice counter == 0.
- o_pcu_last  out  1  slice counter == NSLICE-1.
- o_pcu_pc_q  out  PC_W  full PC register, parallel. Equals the instruction's PC only when o_pcu_first=1.

Behaviour:
- State:
  - pc_q[PC_W-1:0], a rotating shift register.
  - ctr, range 0..NSLICE-1.
  - carry_q, the write-back carry.
  - lcarry_q, the link carry.
  - redir_q and rel_q, the latched redirect request and mode.
- Reset (async, i_pcu_rst=1), immediate and regardless of clock:
  - pc_q=RESET_PC, ctr=0, carry_q=0, lcarry_q=0, redir_q=0, rel_q=0.
  - Outputs during reset: o_pcu_pc_slice=RESET_PC[SLICE_W-1:0], o_pcu_first=1, o_pcu_last=(NSLICE==1).
  - Reset mid-period discards the partial write-back; the next period starts at RESET_PC.
- Slice s = ctr. Per cycle:
  - o_pcu_pc_slice = pc_q[SLICE_W-1:0]. Combinational from the register, zero latency.
  - inc_s = INC slice s.
  - {lc, o_pcu_link_slice} = pc_slice + inc_s + cin_l, where cin_l = (s==0) ? 0 : lcarry_q.
- Write-back slice wb and carry c, by mode (eff_redir = o_pcu_first ? i_pcu_redir_vld : redir_q; same for rel):
  - Sequential (eff_redir=0): {c, wb} = pc_slice + inc_s + cin.
  - Absolute (redir, rel=0): wb = i_pcu_redir_slice, c=0.
  - Relative (redir, rel=1): {c, wb} = pc_slice + i_pcu_redir_slice + cin.
  - cin = (s==0) ? 0 : carry_q.
- Un-stalled rising edge:
  - pc_q <= {wb, pc_q[PC_W-1:SLICE_W]}.
  - carry_q <= c, lcarry_q <= lc.
  - ctr <= (ctr==NSLICE-1) ? 0 : ctr+1.
  - At s==0, redir_q/rel_q latch the effective values.
- Wrap: the carry out of slice NSLICE-1 is discarded, so all arithmetic is modulo 2^PC_W.
- After NSLICE un-stalled cycles, pc_q holds the new PC in its original alignment.
- Stall: with i_pcu_stall=1, no state changes and outputs hold their values. Redirect inputs are ignored except as sampled on an un-stalled o_pcu_first cycle. i_pcu_redir_slice must be held by the source during a stall.
- i_pcu_redir_vld when o_pcu_first=0 is ignored. A redirect always takes effect for a whole period, never part of one.
- Simultaneous stall and redir_vld on a first cycle: the request is sampled on the first un-stalled first cycle.
- NSLICE==1: o_pcu_first = o_pcu_last = 1 permanently; all carries are forced to 0.
- Elaboration: a PC_W not divisible by SLICE_W is a fatal error.

Test Plan:
- Reset, then 8 un-stalled cycles (defaults).
  - Expected: pc slices 0,0,0,0 then 2,0,0,0.
  - Link slices 2,0,0,0.
  - o_pcu_first pulses every 4th cycle; o_pcu_pc_q=0x0002 at the second first.
- Carry chain: run from PC=0x00FE.
  - Expected: next period streams E,F,0,0 -> 0,0,1,0 (PC 0x0100).
  - Link slices equal the next PC's slices.
- Wrap: PC=0xFFFE.
  - Expected: next PC=0x0000; link=0x0000.
- Absolute redirect at PC=0x0010.
  - Stimulus: vld=1, rel=0, redirect slices 4,3,2,1.
  - Expected: next PC=0x1234; the period after that is 0x1236.
- Relative redirect at PC=0x0020.
  - Stimulus: offset 0xFFF0 (slices 0,F,F,F).
  - Expected: next PC=0x0010.
  - Also: vld asserted only on a non-first cycle is ignored, giving PC=0x0022.
- Stall and reset mid-period.
  - Stall 3 cycles at slice 2: outputs frozen, result unchanged (0x1234->0x1236).
  - Assert i_pcu_rst at slice 2: PC immediately RESET_PC with o_pcu_first=1; next period is RESET_PC+2.
